rf_wb_arbiter: RTL and testbench

//  Owns the single register-file write port (wr/addr3/data3) and shares it between the

---
 rtl/cpu_pkg.sv | 15 +
 rtl/rf_wb_fifo.sv | 61 ++++++
 rtl/rf_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the register-file write record.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

    // One register-file write: destination register and value.
    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } rf_wr_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// In-order result buffer for mul/div writebacks waiting for the RF write port.
module rf_wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_push,
    input  rf_wr_t i_push_data,
    input  logic   i_pop,
    output rf_wr_t o_head,
    output logic   o_full,
    output logic   o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

    rf_wr_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_pushOk;
    logic             w_popOk;

    assign o_full   = (r_count == DEPTH_C);
    assign o_empty  = (r_count == '0);
    assign o_head   = r_mem[r_rdPtr];
    assign w_pushOk = i_push && !o_full;
    assign w_popOk  = i_pop && !o_empty;

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (w_pushOk) begin
            r_mem[r_wrPtr] <= i_push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_popOk) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_pushOk && !w_popOk) begin
                r_count <= r_count + 1'b1;
            end else if (w_popOk && !w_pushOk) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: pipeline writeback has priority, mul/div
// results queue behind it; also tracks outstanding mul/div destinations and
// drives the decode stall for hazards and write-port starvation.
module rf_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wb_wr,
    input  logic [REG_AW-1:0] i_wb_addr,
    input  logic [XLEN-1:0]   i_wb_data,
    input  logic              i_lu_valid,
    output logic              o_lu_ready,
    input  logic [REG_AW-1:0] i_lu_addr,
    input  logic [XLEN-1:0]   i_lu_data,
    input  logic              i_lu_issue,
    input  logic [REG_AW-1:0] i_lu_issue_addr,
    input  logic [REG_AW-1:0] i_dec_src1,
    input  logic [REG_AW-1:0] i_dec_src2,
    input  logic [REG_AW-1:0] i_dec_dst,
    output logic              o_stall,
    output logic              o_rf_wr,
    output logic [REG_AW-1:0] o_rf_addr3,
    output logic [XLEN-1:0]   o_rf_data3,
    output logic [XLEN-1:0]   o_pending
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    rf_wr_t           w_head;
    rf_wr_t           w_pushData;
    logic             w_full;
    logic             w_empty;
    logic             w_portBusy;
    logic             w_pop;
    logic             w_push;
    logic             w_starve;
    logic             w_hazard;
    logic             w_issueOk;
    logic [XLEN-1:0]  w_setMask;
    logic [XLEN-1:0]  w_clrMask;
    logic [XLEN-1:0]  r_pending;
    logic [CNT_W-1:0] r_starveCnt;

    assign w_portBusy = i_wb_wr && (i_wb_addr != ZERO_REG);
    assign w_pop      = !w_portBusy && !w_empty;
    assign o_lu_ready = !w_full;
    assign w_push     = i_lu_valid && !w_full;
    assign w_pushData = '{addr: i_lu_addr, data: i_lu_data};

    rf_wb_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_data(w_pushData),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Write-port mux: writeback wins, otherwise drain the buffer head ($0 heads burn the slot silently).
    always_comb begin
        o_rf_wr    = 1'b0;
        o_rf_addr3 = i_wb_addr;
        o_rf_data3 = i_wb_data;
        if (w_portBusy) begin
            o_rf_wr = reset;
        end else if (!w_empty) begin
            o_rf_wr    = reset && (w_head.addr != ZERO_REG);
            o_rf_addr3 = w_head.addr;
            o_rf_data3 = w_head.data;
        end
    end

    // Hazard lookup; bit 0 of the scoreboard is never set, so $0 cannot stall.
    always_comb begin
        w_starve  = (r_starveCnt >= STARVE_LIM);
        w_hazard  = r_pending[i_dec_src1] | r_pending[i_dec_src2] | r_pending[i_dec_dst]
                  | (i_lu_issue & r_pending[i_lu_issue_addr]);
        o_stall   = reset && (w_hazard || w_starve);
        w_issueOk = i_lu_issue && !o_stall && (i_lu_issue_addr != ZERO_REG);
    end

    // Scoreboard edits: set on an accepted issue, clear when that register's result leaves the buffer.
    always_comb begin
        w_setMask = '0;
        w_clrMask = '0;
        if (w_issueOk) begin
            w_setMask[i_lu_issue_addr] = 1'b1;
        end
        if (w_pop && (w_head.addr != ZERO_REG)) begin
            w_clrMask[w_head.addr] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clrMask) | w_setMask;
        end
    end

    assign o_pending = r_pending;

    // Starvation counter: counts cycles the head is blocked by writeback, saturating at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starveCnt <= '0;
        end else if (w_pop || w_empty) begin
            r_starveCnt <= '0;
        end else if (w_portBusy && (r_starveCnt < STARVE_LIM)) begin
            r_starveCnt <= r_starveCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_rf_wb_arbiter;
    import cpu_pkg::*;

    localparam int BUF_DEPTH  = 2;
    localparam int STARVE_MAX = 8;

    logic              clk;
    logic              reset;
    logic              wbWr;
    logic [REG_AW-1:0] wbAddr;
    logic [XLEN-1:0]   wbData;
    logic              luValid;
    logic              luReady;
    logic [REG_AW-1:0] luAddr;
    logic [XLEN-1:0]   luData;
    logic              luIssue;
    logic [REG_AW-1:0] luIssueAddr;
    logic [REG_AW-1:0] decSrc1;
    logic [REG_AW-1:0] decSrc2;
    logic [REG_AW-1:0] decDst;
    logic              stall;
    logic              rfWr;
    logic [REG_AW-1:0] rfAddr3;
    logic [XLEN-1:0]   rfData3;
    logic [XLEN-1:0]   pending;

    rf_wb_arbiter #(
        .BUF_DEPTH (BUF_DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_wb_wr        (wbWr),
        .i_wb_addr      (wbAddr),
        .i_wb_data      (wbData),
        .i_lu_valid     (luValid),
        .o_lu_ready     (luReady),
        .i_lu_addr      (luAddr),
        .i_lu_data      (luData),
        .i_lu_issue     (luIssue),
        .i_lu_issue_addr(luIssueAddr),
        .i_dec_src1     (decSrc1),
        .i_dec_src2     (decSrc2),
        .i_dec_dst      (decDst),
        .o_stall        (stall),
        .o_rf_wr        (rfWr),
        .o_rf_addr3     (rfAddr3),
        .o_rf_data3     (rfData3),
        .o_pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: buffered results, outstanding registers, blocked-cycle count,
    // plus a stand-in mul/div unit holding issued-but-unreturned ops.
    rf_wr_t    mQ[$];
    rf_wr_t    unitQ[$];
    bit [31:0] mPend;
    int        mWait;
    bit        luFromUnit;
    int        checks = 0;
    int        fails  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit modelStall();
        return mPend[decSrc1] | mPend[decSrc2] | mPend[decDst]
             | (luIssue & mPend[luIssueAddr]) | (mWait >= STARVE_MAX);
    endfunction

    // Compare every output against the model for the current input set.
    task automatic checkCycle();
        bit busy;
        busy = wbWr && (wbAddr != 0);
        if (busy) begin
            checkOutput("rfWr", rfWr, 1);
            checkOutput("rfAddr3", rfAddr3, wbAddr);
            checkOutput("rfData3", rfData3, wbData);
        end else if (mQ.size() > 0) begin
            checkOutput("rfWr", rfWr, mQ[0].addr != 0);
            checkOutput("rfAddr3", rfAddr3, mQ[0].addr);
            checkOutput("rfData3", rfData3, mQ[0].data);
        end else begin
            checkOutput("rfWr", rfWr, 0);
        end
        checkOutput("luReady", luReady, mQ.size() < BUF_DEPTH);
        checkOutput("stall", stall, modelStall());
        checkOutput("pending", pending, mPend);
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic modelEdge();
        bit busy, pop, accept, stl;
        rf_wr_t e;
        busy   = wbWr && (wbAddr != 0);
        pop    = !busy && (mQ.size() > 0);
        accept = luValid && (mQ.size() < BUF_DEPTH);
        stl    = modelStall();
        if (pop || mQ.size() == 0) mWait = 0;
        else if (busy && mWait < STARVE_MAX) mWait++;
        if (pop) begin
            e = mQ.pop_front();
            if (e.addr != 0) mPend[e.addr] = 1'b0;
        end
        if (accept) begin
            mQ.push_back('{addr: luAddr, data: luData});
            if (luFromUnit && unitQ.size() > 0) void'(unitQ.pop_front());
        end
        if (luIssue && !stl) begin
            if (luIssueAddr != 0) mPend[luIssueAddr] = 1'b1;
            unitQ.push_back('{addr: luIssueAddr, data: $urandom});
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        checkCycle();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic idleInputs();
        wbWr = 0; wbAddr = 0; wbData = 0;
        luValid = 0; luAddr = 0; luData = 0; luFromUnit = 0;
        luIssue = 0; luIssueAddr = 0;
        decSrc1 = 0; decSrc2 = 0; decDst = 0;
    endtask

    // Randomized traffic with a small register range to provoke hazards.
    task automatic applyStimulus();
        wbWr   = ($urandom_range(0, 9) < 6);
        wbAddr = 5'($urandom_range(0, 7));
        wbData = $urandom;
        luIssue     = ($urandom_range(0, 9) < 3);
        luIssueAddr = 5'($urandom_range(0, 7));
        decSrc1 = 5'($urandom_range(0, 7));
        decSrc2 = 5'($urandom_range(0, 7));
        decDst  = 5'($urandom_range(0, 7));
        luFromUnit = 0;
        if (unitQ.size() > 0 && $urandom_range(0, 1) == 1) begin
            luValid = 1; luAddr = unitQ[0].addr; luData = unitQ[0].data; luFromUnit = 1;
        end else if ($urandom_range(0, 7) == 0) begin
            luValid = 1; luAddr = 0; luData = $urandom;
        end else begin
            luValid = 0; luAddr = 5'($urandom_range(0, 31)); luData = $urandom;
        end
    endtask

    task automatic modelClear();
        mQ.delete();
        unitQ.delete();
        mPend = '0;
        mWait = 0;
    endtask

    initial begin
        int waited;
        reset = 0;
        idleInputs();
        modelClear();
        #2;
        checkOutput("resetRfWr", rfWr, 0);
        checkOutput("resetStall", stall, 0);
        checkOutput("resetReady", luReady, 1);
        checkOutput("resetPending", pending, 0);
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;

        // Issue r5, return r5=0x1234 with the port idle, watch the stall on src1=5 clear.
        luIssue = 1; luIssueAddr = 5;
        cycle();
        luIssue = 0; decSrc1 = 5;
        luValid = 1; luAddr = 5; luData = 32'h1234; luFromUnit = 1;
        cycle();
        checkOutput("s1Pending5", pending[5], 1);
        luValid = 0;
        cycle();
        cycle();
        checkOutput("s1Unstalled", stall, 0);
        idleInputs();

        // Issue r7, buffer its result behind a long writeback burst on r3.
        luIssue = 1; luIssueAddr = 7;
        cycle();
        luIssue = 0;
        wbWr = 1; wbAddr = 3; wbData = 32'hCAFE_0003;
        luValid = 1; luAddr = 7; luData = 32'h7777; luFromUnit = 1;
        cycle();
        luValid = 0; luFromUnit = 0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall) break;
            waited++;
            @(posedge clk); modelEdge(); #1;
        end
        checkOutput("s2StarveDelay", waited, STARVE_MAX);
        cycle();
        wbWr = 0;
        cycle();
        checkOutput("s2Drained", pending[7], 0);
        cycle();

        // Fill the buffer with r5 and r9 behind writeback, then hit async reset.
        idleInputs();
        luIssue = 1; luIssueAddr = 5; cycle();
        luIssueAddr = 9; cycle();
        luIssue = 0;
        wbWr = 1; wbAddr = 3; wbData = 32'h3333;
        luValid = 1; luAddr = unitQ[0].addr; luData = unitQ[0].data; luFromUnit = 1; cycle();
        luAddr = unitQ[0].addr; luData = unitQ[0].data; cycle();
        luValid = 0; luFromUnit = 0; decSrc1 = 5;
        cycle();
        checkOutput("s6PendingBefore", pending, 32'h0000_0220);
        @(negedge clk);
        #2 reset = 0;
        #1;
        checkOutput("s6RfWr", rfWr, 0);
        checkOutput("s6Stall", stall, 0);
        checkOutput("s6Ready", luReady, 1);
        checkOutput("s6Pending", pending, 0);
        modelClear();
        idleInputs();
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            applyStimulus();
            cycle();
        end

        $display("[TB] %0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
